// File: rtl/cs_loader.sv
// Power-on microcode loader: copies the control-store EPROM into RAM,
// optionally reads it back for comparison, then releases the machine.
module cs_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int READ_WAIT  = 1,
    parameter int VERIFY     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reload,
    output logic [ADDR_WIDTH-1:0] cs_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram__w,
    output logic                  busy,
    output logic                  cs_ready,
    output logic                  load_error,
    output logic [ADDR_WIDTH-1:0] error_addr
);

    localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(READ_WAIT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_INIT,
        S_COPY_RD,
        S_COPY_WR,
        S_COPY_HOLD,
        S_VER_RD,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         wait_cnt, wait_cnt_n;
    logic [ADDR_WIDTH-1:0] cs_addr_n, error_addr_n;
    logic [DATA_WIDTH-1:0] ram_wdata_n;
    logic                  ram__w_n, busy_n, cs_ready_n, load_error_n;
    logic                  wait_last, addr_last;

    assign wait_last = (wait_cnt == WAIT_LAST);
    assign addr_last = (cs_addr == ADDR_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_INIT;
            wait_cnt   <= '0;
            cs_addr    <= '0;
            ram_wdata  <= '0;
            ram__w     <= 1'b1;
            busy       <= 1'b0;
            cs_ready   <= 1'b0;
            load_error <= 1'b0;
            error_addr <= '0;
        end else begin
            state      <= state_n;
            wait_cnt   <= wait_cnt_n;
            cs_addr    <= cs_addr_n;
            ram_wdata  <= ram_wdata_n;
            ram__w     <= ram__w_n;
            busy       <= busy_n;
            cs_ready   <= cs_ready_n;
            load_error <= load_error_n;
            error_addr <= error_addr_n;
        end
    end

    // Outputs are computed one cycle ahead so every pin comes from a flop.
    always_comb begin
        state_n      = state;
        wait_cnt_n   = wait_cnt;
        cs_addr_n    = cs_addr;
        ram_wdata_n  = ram_wdata;
        ram__w_n     = 1'b1;
        busy_n       = busy;
        cs_ready_n   = cs_ready;
        load_error_n = load_error;
        error_addr_n = error_addr;
        unique case (state)
            S_INIT: begin
                state_n    = S_COPY_RD;
                wait_cnt_n = '0;
                cs_addr_n  = '0;
                busy_n     = 1'b1;
                cs_ready_n = 1'b0;
            end
            S_COPY_RD: begin
                if (wait_last) begin
                    wait_cnt_n  = '0;
                    ram_wdata_n = rom_data;
                    ram__w_n    = 1'b0;
                    state_n     = S_COPY_WR;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            S_COPY_WR: begin
                state_n = S_COPY_HOLD;
            end
            S_COPY_HOLD: begin
                if (addr_last) begin
                    cs_addr_n = '0;
                    if (VERIFY != 0) begin
                        state_n = S_VER_RD;
                    end else begin
                        state_n    = S_DONE;
                        busy_n     = 1'b0;
                        cs_ready_n = 1'b1;
                    end
                end else begin
                    cs_addr_n = cs_addr + 1'b1;
                    state_n   = S_COPY_RD;
                end
            end
            S_VER_RD: begin
                if (wait_last) begin
                    wait_cnt_n = '0;
                    if (ram_rdata != rom_data) begin
                        error_addr_n = cs_addr;
                        load_error_n = 1'b1;
                        busy_n       = 1'b0;
                        state_n      = S_ERROR;
                    end else if (addr_last) begin
                        cs_addr_n  = '0;
                        busy_n     = 1'b0;
                        cs_ready_n = 1'b1;
                        state_n    = S_DONE;
                    end else begin
                        cs_addr_n = cs_addr + 1'b1;
                    end
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            S_DONE: begin
                if (reload) begin
                    state_n    = S_INIT;
                    cs_addr_n  = '0;
                    cs_ready_n = 1'b0;
                end
            end
            S_ERROR: begin
                if (reload) begin
                    state_n      = S_INIT;
                    cs_addr_n    = '0;
                    load_error_n = 1'b0;
                    error_addr_n = '0;
                end
            end
            default: begin
                state_n = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cs_loader.sv
// Bench for cs_loader: default instance plus a slow-read copy-only
// instance, checked against array models of the EPROM and RAM.
module tb_cs_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, reload, ram__w, busy, cs_ready, load_error;
    logic [7:0]  cs_addr, error_addr;
    logic [63:0] rom_data, ram_rdata, ram_wdata;

    logic        reset_b, reload_b, ram__w_b, busy_b, cs_ready_b, load_error_b;
    logic [7:0]  cs_addr_b, error_addr_b;
    logic [63:0] rom_data_b, ram_rdata_b, ram_wdata_b;

    logic [63:0] rom [256];
    logic [63:0] ram [256];
    logic [63:0] rom_b [256];
    logic [63:0] ram_b [256];
    bit          fault = 1'b0;

    assign rom_data    = rom[cs_addr];
    assign ram_rdata   = ram[cs_addr] ^ ((fault && cs_addr == 8'h5A) ? 64'h8 : 64'h0);
    assign rom_data_b  = rom_b[cs_addr_b];
    assign ram_rdata_b = ram_b[cs_addr_b];

    cs_loader dut (
        .clk(clk), .reset(reset), .reload(reload), .cs_addr(cs_addr),
        .rom_data(rom_data), .ram_rdata(ram_rdata), .ram_wdata(ram_wdata),
        .ram__w(ram__w), .busy(busy), .cs_ready(cs_ready),
        .load_error(load_error), .error_addr(error_addr)
    );

    cs_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .READ_WAIT(3), .VERIFY(0)) dut_b (
        .clk(clk), .reset(reset_b), .reload(reload_b), .cs_addr(cs_addr_b),
        .rom_data(rom_data_b), .ram_rdata(ram_rdata_b), .ram_wdata(ram_wdata_b),
        .ram__w(ram__w_b), .busy(busy_b), .cs_ready(cs_ready_b),
        .load_error(load_error_b), .error_addr(error_addr_b)
    );

    int ecnt = 0;
    int base = 0;
    int base_b = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    // Write-strobe log: address and edge number of every low cycle.
    logic [7:0] pq[$];
    logic [7:0] pq_b[$];
    int         pe[$];
    int         pe_b[$];
    always @(negedge clk) begin
        if (ram__w === 1'b0) begin
            ram[cs_addr] = ram_wdata;
            pq.push_back(cs_addr);
            pe.push_back(ecnt - base);
        end
        if (ram__w_b === 1'b0) begin
            ram_b[cs_addr_b] = ram_wdata_b;
            pq_b.push_back(cs_addr_b);
            pe_b.push_back(ecnt - base_b);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full copy = 256 single-cycle strobes, ascending, at off+per*i.
    task automatic check_copy(input string tag, input bit b, input int st,
                              input int off, input int per);
        int n, bad, mism;
        n = b ? pq_b.size() - st : pq.size() - st;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] a;
            int e;
            a = b ? pq_b[st+i] : pq[st+i];
            e = b ? pe_b[st+i] : pe[st+i];
            if (a !== 8'(i) || e != off + per * i) bad++;
        end
        mism = 0;
        for (int i = 0; i < 256; i++) begin
            if (b ? (ram_b[i] !== rom_b[i]) : (ram[i] !== rom[i])) mism++;
        end
        check({tag, "_pulses"}, 64'(n), 64'd256);
        check({tag, "_order"}, 64'(bad), 64'd0);
        check({tag, "_ram"}, 64'(mism), 64'd0);
    endtask

    task automatic wait_ready(input bit b, input int budget, output int at, output logic pb);
        at = -1;
        pb = 1'bx;
        for (int n = 0; n < budget; n++) begin
            logic prev;
            prev = b ? busy_b : busy;
            @(posedge clk);
            #1;
            if ((b ? cs_ready_b : cs_ready) === 1'b1) begin
                at = ecnt - (b ? base_b : base);
                pb = prev;
                break;
            end
        end
    endtask

    task automatic fresh_rom();
        for (int i = 0; i < 256; i++) rom[i] = {$urandom, $urandom};
    endtask

    initial begin
        int   st, at, e, k;
        logic pb;
        reset = 1'b1; reload = 1'b0;
        reset_b = 1'b1; reload_b = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom[i]   = 64'(i) * 64'h0101_0101_0101_0101;
            rom_b[i] = {$urandom, $urandom};
        end
        repeat (3) @(negedge clk);

        check("rst_addr", 64'(cs_addr), 64'd0);
        check("rst_wdata", ram_wdata, 64'd0);
        check("rst_we", 64'(ram__w), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(cs_ready), 64'd0);
        check("rst_err", 64'(load_error), 64'd0);
        check("rst_eaddr", 64'(error_addr), 64'd0);

        // Default copy + verify from reset release
        st = pq.size(); base = ecnt; reset = 1'b0;
        @(posedge clk); #1;
        check("t1_busy_e1", 64'(busy), 64'd1);
        check("t1_ready_e1", 64'(cs_ready), 64'd0);
        wait_ready(1'b0, 1100, at, pb);
        check("t1_ready_edge", 64'(at), 64'(1 + 3 * 256 + 256));
        check("t1_busy_fall", 64'(busy), 64'd0);
        check("t1_busy_prev", 64'(pb), 64'd1);
        check("t1_addr_done", 64'(cs_addr), 64'd0);
        check_copy("t1", 1'b0, st, 2, 3);

        // Reload from DONE; a second reload during COPY_RD is ignored
        @(negedge clk);
        fresh_rom();
        reload = 1'b1; st = pq.size(); base = ecnt + 1;
        @(posedge clk); #1;
        check("t5_ready_drop", 64'(cs_ready), 64'd0);
        @(negedge clk);
        reload = 1'b0;
        while (ecnt - base < 49) @(negedge clk);
        check("t5_addr_rd", 64'(cs_addr), 64'((49 - 1) / 3));
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        wait_ready(1'b0, 1100, at, pb);
        check("t5_ready_edge", 64'(at), 64'd1025);
        check_copy("t5", 1'b0, st, 2, 3);

        // Readback fault on word 0x5A
        reset = 1'b1; fault = 1'b1;
        fresh_rom();
        repeat (2) @(negedge clk);
        st = pq.size(); base = ecnt; reset = 1'b0;
        at = -1;
        for (int n = 0; n < 1200; n++) begin
            @(posedge clk); #1;
            if (load_error === 1'b1) begin
                at = ecnt - base;
                break;
            end
        end
        check("t2_err_edge", 64'(at), 64'(1 + 3 * 256 + 8'h5A + 1));
        check("t2_eaddr", 64'(error_addr), 64'h5A);
        repeat (20) @(negedge clk);
        check("t2_err_sticky", 64'(load_error), 64'd1);
        check("t2_ready_low", 64'(cs_ready), 64'd0);
        check("t2_busy_low", 64'(busy), 64'd0);
        check_copy("t2", 1'b0, st, 2, 3);
        fault = 1'b0;
        reload = 1'b1; base = ecnt + 1;
        @(posedge clk); #1;
        check("t2_err_clr", 64'(load_error), 64'd0);
        check("t2_eaddr_clr", 64'(error_addr), 64'd0);
        @(negedge clk);
        reload = 1'b0;
        wait_ready(1'b0, 1100, at, pb);
        check("t2_ready_edge", 64'(at), 64'd1025);

        // Reset mid-copy on an edge that would otherwise drop ram__w
        reset = 1'b1;
        fresh_rom();
        repeat (2) @(negedge clk);
        base = ecnt; reset = 1'b0;
        k = int'($urandom_range(100, 200));
        e = 2 + 3 * k;
        while (ecnt - base < e - 1) @(negedge clk);
        check("t3_addr_pre", 64'(cs_addr), 64'(k));
        check("t3_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t3_we", 64'(ram__w), 64'd1);
        check("t3_addr", 64'(cs_addr), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        st = pq.size(); base = ecnt; reset = 1'b0;
        wait_ready(1'b0, 1100, at, pb);
        check("t3_ready_edge", 64'(at), 64'd1025);
        check_copy("t3", 1'b0, st, 2, 3);

        // READ_WAIT=3, no verify
        check("t4_rst_ready", 64'(cs_ready_b), 64'd0);
        check("t4_rst_we", 64'(ram__w_b), 64'd1);
        st = pq_b.size(); base_b = ecnt; reset_b = 1'b0;
        wait_ready(1'b1, 1400, at, pb);
        check("t4_ready_edge", 64'(at), 64'(1 + 5 * 256));
        check("t4_busy_fall", 64'(busy_b), 64'd0);
        check("t4_err", 64'(load_error_b), 64'd0);
        check_copy("t4", 1'b1, st, 4, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
